// File: rtl/gtx_frame_gen.sv
// GTX TX frame generator: comma idle, header with sequence number, then counter or
// PRBS-7 payload words ending in a fixed trailer. All outputs are registered.
module gtx_frame_gen #(
    parameter int          BYTES         = 4,
    parameter int          PAYLOAD_WORDS = 1,
    parameter int          SEQ_WIDTH     = 14,
    parameter logic [7:0]  COMMA         = 8'hBC,
    parameter logic [15:0] TRAILER       = 16'h0E0D
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 EN,
    input  logic                 TX_READY,
    input  logic                 MODE,
    output logic [8*BYTES-1:0]   gt0_txdata,
    output logic [BYTES-1:0]     gt0_txcharisk,
    output logic                 FRAME_START,
    output logic [31:0]          FRAME_CNT
);

    localparam int               W         = 8 * BYTES;
    localparam int               HALF      = 4 * BYTES;
    localparam logic [W-1:0]     IDLE_WORD = {BYTES{COMMA}};
    localparam logic [BYTES-1:0] HDR_ISK   = BYTES'((1 << (BYTES / 2)) - 1);
    localparam logic [8:0]       LAST_CNT  = 9'(PAYLOAD_WORDS);

    typedef enum logic [1:0] {IDLE, HDR, PAY} state_t;

    state_t               state;
    logic [SEQ_WIDTH-1:0] seq;
    logic [SEQ_WIDTH-1:0] seq_inc;
    logic [6:0]           lfsr;
    logic [6:0]           lfsr_src;
    logic [6:0]           lfsr_nxt;
    logic [7:0]           p;
    logic [7:0]           p_src;
    logic [7:0]           p_nxt;
    logic [8:0]           pay_cnt;
    logic                 frame_mode;
    logic                 mode_src;
    logic                 last_word;
    logic                 fb;
    logic [W-1:0]         pay_word;
    logic [W-1:0]         hdr_cur;
    logic [W-1:0]         hdr_inc;

    // Header: commas in the lower half, sequence number left-justified in the upper half.
    function automatic logic [W-1:0] hdr_word(input logic [SEQ_WIDTH-1:0] s);
        logic [W-1:0] w;
        w = IDLE_WORD;
        w[W-1 -: HALF] = HALF'(s) << (HALF - SEQ_WIDTH);
        return w;
    endfunction

    // The output register holds the word of the state being entered, so the first payload
    // word is generated while still in HDR from the fresh seed and a zero byte counter.
    always_comb begin
        lfsr_src  = (state == HDR) ? 7'h7F : lfsr;
        p_src     = (state == HDR) ? 8'd0 : p;
        mode_src  = (state == HDR) ? MODE : frame_mode;
        last_word = (state == HDR) ? (LAST_CNT == 9'd1) : (pay_cnt == LAST_CNT - 9'd1);
        lfsr_nxt  = lfsr_src;
        pay_word  = '0;
        fb        = 1'b0;
        for (int b = 0; b < BYTES; b++) begin
            for (int k = 7; k >= 0; k--) begin
                fb       = lfsr_nxt[6] ^ lfsr_nxt[5];
                lfsr_nxt = {lfsr_nxt[5:0], fb};
                if (mode_src) begin
                    pay_word[8*b+k] = fb;
                end
            end
            if (!mode_src) begin
                pay_word[8*b +: 8] = p_src + 8'(b);
            end
        end
        if (last_word) begin
            pay_word[W-1 -: 16] = TRAILER;
        end
        p_nxt   = p_src + 8'(BYTES);
        seq_inc = seq + 1'b1;
        hdr_cur = hdr_word(seq);
        hdr_inc = hdr_word(seq_inc);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= IDLE;
            gt0_txdata    <= IDLE_WORD;
            gt0_txcharisk <= '1;
            FRAME_START   <= 1'b0;
            FRAME_CNT     <= 32'd0;
            seq           <= '0;
            lfsr          <= 7'h7F;
            p             <= 8'd0;
            pay_cnt       <= 9'd0;
            frame_mode    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (EN && TX_READY) begin
                        state         <= HDR;
                        gt0_txdata    <= hdr_cur;
                        gt0_txcharisk <= HDR_ISK;
                        FRAME_START   <= 1'b1;
                    end else begin
                        gt0_txdata    <= IDLE_WORD;
                        gt0_txcharisk <= '1;
                        FRAME_START   <= 1'b0;
                    end
                end
                HDR: begin
                    if (!TX_READY) begin
                        state         <= IDLE;
                        gt0_txdata    <= IDLE_WORD;
                        gt0_txcharisk <= '1;
                        FRAME_START   <= 1'b0;
                    end else begin
                        state         <= PAY;
                        gt0_txdata    <= pay_word;
                        gt0_txcharisk <= '0;
                        FRAME_START   <= 1'b0;
                        frame_mode    <= MODE;
                        lfsr          <= lfsr_nxt;
                        p             <= p_nxt;
                        pay_cnt       <= 9'd1;
                    end
                end
                PAY: begin
                    if (!TX_READY) begin
                        state         <= IDLE;
                        gt0_txdata    <= IDLE_WORD;
                        gt0_txcharisk <= '1;
                        FRAME_START   <= 1'b0;
                    end else if (pay_cnt == LAST_CNT) begin
                        FRAME_CNT <= FRAME_CNT + 32'd1;
                        seq       <= seq_inc;
                        if (EN) begin
                            state         <= HDR;
                            gt0_txdata    <= hdr_inc;
                            gt0_txcharisk <= HDR_ISK;
                            FRAME_START   <= 1'b1;
                        end else begin
                            state         <= IDLE;
                            gt0_txdata    <= IDLE_WORD;
                            gt0_txcharisk <= '1;
                            FRAME_START   <= 1'b0;
                        end
                    end else begin
                        gt0_txdata <= pay_word;
                        lfsr       <= lfsr_nxt;
                        p          <= p_nxt;
                        pay_cnt    <= pay_cnt + 9'd1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    gt0_txdata    <= IDLE_WORD;
                    gt0_txcharisk <= '1;
                    FRAME_START   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/gtx_frame_gen.md
# gtx_frame_gen

Parametrised GTX transmit frame generator for the loopback test path, driving a GTX TX user interface. It emits comma-framed frames: a header word carrying K-character commas and a per-frame sequence number, then a configurable number of payload words in counter or PRBS-7 mode, ending in a fixed trailer. Between frames it emits all-comma idle words. It adds enable, link-ready gating, back-to-back framing and frame counting to the fixed two-word header/data pattern generator used so far.

## Interface
Parameters:
- BYTES, 4: bytes per TX word. Must be even, 2..8. Word width W = 8*BYTES.
- PAYLOAD_WORDS, 1: payload words per frame, 1..255.
- SEQ_WIDTH, 14: sequence number width. Must be ≤ 4*BYTES.
- COMMA, 8'hBC: K-character used for the header and for idle.
- TRAILER, 16'h0E0D: value placed in the top two bytes of the last payload word.

Ports:
- CLK  in  1  TX user clock; the only clock.
- RST_N  in  1  reset, asynchronous and active-low.
- EN  in  1  frame generation enable (level).
- TX_READY  in  1  GTX TX reset done / user ready (level).
- MODE  in  1  payload mode: 0 = counter, 1 = PRBS-7.
- gt0_txdata  out  W  TX data word; byte 0 is bits [7:0].
- gt0_txcharisk  out  BYTES  per-byte K flag; bit i qualifies byte i.
- FRAME_START  out  1  high while a header word is on gt0_txdata.
- FRAME_CNT  out  32  number of completed frames.

## Operation
- State machine states: IDLE, HDR, PAY.
- IDLE: gt0_txdata = {BYTES{COMMA}}, gt0_txcharisk = all ones.
  - Goes to HDR when EN and TX_READY are both sampled high.
- HDR: lasts one cycle.
  - Lower BYTES/2 bytes = COMMA, with the matching charisk bits = 1.
  - Upper half = seq left-justified and zero-padded in the LSBs; those charisk bits = 0. For BYTES=4, SEQ_WIDTH=14 this is {seq, 2'b00}.
  - Samples MODE into a frame-mode register, which holds for the whole frame.
  - Clears the byte counter p to 0 and reseeds the PRBS-7 LFSR to 7'h7F.
  - Goes to PAY.
- PAY: lasts PAYLOAD_WORDS cycles; gt0_txcharisk = 0.
  - Counter mode: byte i = p+i (mod 256), and p advances by BYTES after each word.
  - PRBS-7 mode: polynomial x^7+x^6+1. Each byte is the next 8 generator output bits, first bit in the MSB. Bytes are filled from byte 0 upward, and the LFSR state carries across words.
  - On the last payload word, bytes [BYTES-1:BYTES-2] are replaced by TRAILER (8'h0E in the MSB byte). The LFSR and p still advance as if those bytes had not been replaced.
  - After the last payload word: the frame is complete, so FRAME_CNT increments and seq increments modulo 2^SEQ_WIDTH.
  - Next state is HDR if EN and TX_READY are both high (back-to-back frames, no idle word), otherwise IDLE.
- EN falling mid-frame: the current frame completes normally.
- TX_READY falling in HDR or PAY: the frame is aborted.
  - IDLE words appear from the next cycle.
  - Neither seq nor FRAME_CNT changes, so the retried frame reuses the same seq.
- MODE changing mid-frame has no effect until the next header.
- FRAME_CNT wraps from 2^32-1 to 0.

## Timing
- All outputs are registered, and nothing is combinational from the inputs.
- An input sampled at edge n affects the outputs from edge n+1.
- Reset values: gt0_txdata = {BYTES{COMMA}}, gt0_txcharisk = all ones, FRAME_START = 0, FRAME_CNT = 0, seq = 0, state IDLE.
- Reset asserted asynchronously mid-frame forces the outputs to these values immediately. The first header after release carries seq 0.
- Frame length is exactly 1+PAYLOAD_WORDS cycles. The back-to-back frame period is the same.
- FRAME_START is high for exactly one cycle per frame, aligned with the header word.
- FRAME_CNT updates on the same edge that the state leaves the last PAY word.

## Test plan
- Defaults, EN = TX_READY = 1 from reset release. Expected sequence:
  - idle: 32'hBCBCBCBC / 4'hF;
  - header: 32'h0000BCBC / 4'h3;
  - payload: 32'h0E0D0100 / 4'h0;
  - header: 32'h0004BCBC;
  - FRAME_CNT counts 1, 2, ...
- PAYLOAD_WORDS=3, MODE=0 → payload words 32'h03020100, 32'h07060504, 32'h0E0D0908, then back-to-back header.
- Wrap: run 2^14+1 frames → the header after seq 14'h3FFF carries 16'h0000 in its upper half, and FRAME_CNT = 16385.
- TX_READY dropped during PAY → an idle word on the next cycle, and FRAME_CNT is unchanged. After TX_READY returns, the header repeats the same seq.
- EN dropped at a header → the frame finishes, with payload and trailer emitted, then idle words; FRAME_START pulses exactly once.
- BYTES=8, PAYLOAD_WORDS=4, MODE=1 → payload bytes match a bit-serial PRBS-7 model seeded 7'h7F. Trailer bytes sit at [63:48], and the LFSR is reseeded at every header.
